cache_lru_fill_arbiter: RTL and testbench

- Shares one cache_lru instance between NUM_REQUESTERS fill requesters (miss handlers / threads) and one hit-access client.
- Round-robin arbitration for the single fill port; returns the victim way with requester ID one cycle after grant.
- Fill beats access, but a bounded starvation counter guarantees forward progress for the access client.
- Blocks any LRU update whose access read was preempted.

---
 rtl/cache_lru_fill_arbiter.sv | 95 +++++++++
 tb/tb_cache_lru_fill_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cache_lru_fill_arbiter.sv
// cache_lru_fill_arbiter: round-robin fill arbitration with a starvation-bounded access client over one cache_lru.
// Fill always beats access until MAX_DROPS consecutive accesses have been preempted.
module cache_lru_fill_arbiter #(
    parameter int NUM_SETS        = 64,
    parameter int NUM_WAYS        = 4,
    parameter int NUM_REQUESTERS  = 4,
    parameter int MAX_DROPS       = 3,
    parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
    parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int REQ_ID_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NUM_REQUESTERS-1:0]                 req_valid_i,
    input  logic [NUM_REQUESTERS*SET_INDEX_WIDTH-1:0] req_set_i,
    output logic [NUM_REQUESTERS-1:0]                 req_ready_o,
    output logic                                      resp_valid_o,
    output logic [REQ_ID_WIDTH-1:0]                   resp_id_o,
    output logic [SET_INDEX_WIDTH-1:0]                resp_set_o,
    output logic [WAY_INDEX_WIDTH-1:0]                resp_way_o,
    input  logic                                      acc_en_i,
    input  logic [SET_INDEX_WIDTH-1:0]                acc_set_i,
    input  logic                                      acc_hit_i,
    input  logic [WAY_INDEX_WIDTH-1:0]                acc_hit_way_i,
    output logic                                      acc_dropped_o,
    output logic                                      lru_fill_en_o,
    output logic [SET_INDEX_WIDTH-1:0]                lru_fill_set_o,
    input  logic [WAY_INDEX_WIDTH-1:0]                lru_fill_way_i,
    output logic                                      lru_access_en_o,
    output logic [SET_INDEX_WIDTH-1:0]                lru_access_set_o,
    output logic                                      lru_update_en_o,
    output logic [WAY_INDEX_WIDTH-1:0]                lru_update_way_o
);
    logic [REQ_ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d, gnt_id, idx, resp_id_q;
    logic [3:0]                 drop_cnt_q, drop_cnt_d;
    logic [SET_INDEX_WIDTH-1:0] resp_set_q;
    logic                       starve, found, acc_drop;
    logic                       resp_valid_q, acc_dropped_q, access_granted_q;

    assign starve = acc_en_i && drop_cnt_q == 4'(MAX_DROPS);

    // Search from rr_ptr upward; ID arithmetic wraps because NUM_REQUESTERS is a power of two.
    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            idx = rr_ptr_q + REQ_ID_WIDTH'(i);
            if (!found && !starve && req_valid_i[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
    end

    assign req_ready_o      = found ? {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << gnt_id : '0;
    assign lru_fill_en_o    = found;
    assign lru_fill_set_o   = req_set_i[gnt_id*SET_INDEX_WIDTH +: SET_INDEX_WIDTH];
    assign lru_access_en_o  = acc_en_i && !found;
    assign lru_access_set_o = acc_set_i;
    assign acc_drop         = acc_en_i && found;
    assign rr_ptr_d         = found ? gnt_id + 1'b1 : rr_ptr_q;
    assign drop_cnt_d       = lru_access_en_o ? 4'd0 :
                              (acc_drop && drop_cnt_q != 4'(MAX_DROPS)) ? drop_cnt_q + 4'd1 : drop_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q         <= '0;
            drop_cnt_q       <= '0;
            resp_valid_q     <= 1'b0;
            resp_id_q        <= '0;
            resp_set_q       <= '0;
            acc_dropped_q    <= 1'b0;
            access_granted_q <= 1'b0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            drop_cnt_q       <= drop_cnt_d;
            resp_valid_q     <= found;
            acc_dropped_q    <= acc_drop;
            access_granted_q <= lru_access_en_o;
            if (found) begin
                resp_id_q  <= gnt_id;
                resp_set_q <= lru_fill_set_o;
            end
        end
    end

    assign resp_valid_o     = resp_valid_q;
    assign resp_id_o        = resp_id_q;
    assign resp_set_o       = resp_set_q;
    assign resp_way_o       = lru_fill_way_i;
    assign acc_dropped_o    = acc_dropped_q;
    assign lru_update_en_o  = acc_hit_i && access_granted_q;
    assign lru_update_way_o = acc_hit_way_i;
endmodule

// File: tb/tb_cache_lru_fill_arbiter.sv
// tb_cache_lru_fill_arbiter: directed literal checks plus randomized traffic against a behavioural model.
module tb_cache_lru_fill_arbiter;
    localparam int N = 4, SIW = 6, WIW = 2, RIW = 2, MD = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]     req_valid = '0, req_ready;
    logic [N*SIW-1:0] req_set = '0;
    logic             resp_valid, acc_dropped, lru_fill_en, lru_access_en, lru_update_en;
    logic [RIW-1:0]   resp_id;
    logic [SIW-1:0]   resp_set, lru_fill_set, lru_access_set, acc_set = '0;
    logic [WIW-1:0]   resp_way, lru_update_way, acc_hit_way = '0, lru_fill_way = '0;
    logic             acc_en = 1'b0, acc_hit = 1'b0;

    cache_lru_fill_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_set_i(req_set), .req_ready_o(req_ready),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_set_o(resp_set), .resp_way_o(resp_way),
        .acc_en_i(acc_en), .acc_set_i(acc_set), .acc_hit_i(acc_hit), .acc_hit_way_i(acc_hit_way),
        .acc_dropped_o(acc_dropped),
        .lru_fill_en_o(lru_fill_en), .lru_fill_set_o(lru_fill_set), .lru_fill_way_i(lru_fill_way),
        .lru_access_en_o(lru_access_en), .lru_access_set_o(lru_access_set),
        .lru_update_en_o(lru_update_en), .lru_update_way_o(lru_update_way)
    );

    int n_vec = 0, n_err = 0, cg;
    bit chk = 1'b0;
    int m_ptr, m_drops, m_rid, m_rset;
    bit m_rv, m_ag, m_dropped;

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mgrant();
        if (acc_en && m_drops == MD) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic mreset();
        m_ptr = 0; m_drops = 0; m_rid = 0; m_rset = 0;
        m_rv = 0; m_ag = 0; m_dropped = 0;
    endtask

    task automatic upd();
        int g;
        g = mgrant();
        m_rv = (g >= 0);
        if (g >= 0) begin
            m_rid  = g;
            m_rset = int'(req_set[g*SIW +: SIW]);
            m_ptr  = (g + 1) % N;
        end
        m_dropped = acc_en && g >= 0;
        m_ag      = acc_en && g < 0;
        if (m_ag) m_drops = 0;
        else if (m_dropped && m_drops < MD) m_drops++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) upd(); else mreset();
        #1;
    endtask

    always @(negedge clk) if (chk && rst_n) begin
        cg = mgrant();
        cmp("req_ready", int'(req_ready), cg >= 0 ? (1 << cg) : 0);
        cmp("fill_en", int'(lru_fill_en), int'(cg >= 0));
        if (cg >= 0) cmp("fill_set", int'(lru_fill_set), int'(req_set[cg*SIW +: SIW]));
        cmp("access_en", int'(lru_access_en), int'(acc_en && cg < 0));
        cmp("access_set", int'(lru_access_set), int'(acc_set));
        cmp("update_en", int'(lru_update_en), int'(acc_hit && m_ag));
        cmp("update_way", int'(lru_update_way), int'(acc_hit_way));
        cmp("resp_valid", int'(resp_valid), int'(m_rv));
        cmp("acc_dropped", int'(acc_dropped), int'(m_dropped));
        if (m_rv) begin
            cmp("resp_id", int'(resp_id), m_rid);
            cmp("resp_set", int'(resp_set), m_rset);
            cmp("resp_way", int'(resp_way), int'(lru_fill_way));
        end
    end

    initial begin
        mreset();
        req_valid = 4'b1111;
        tick(); tick();
        cmp("rst_resp_valid", int'(resp_valid), 0);
        cmp("rst_acc_dropped", int'(acc_dropped), 0);
        rst_n = 1'b1; chk = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            cmp("rr_order", int'(req_ready), 1 << (k % 4));
            if (k > 0) cmp("rr_resp_id", int'(resp_id), (k - 1) % 4);
            tick();
        end
        req_valid = 4'b0100; req_set[2*SIW +: SIW] = 6'd5; lru_fill_way = 2'd3;
        #1;
        cmp("single_fill_en", int'(lru_fill_en), 1);
        cmp("single_fill_set", int'(lru_fill_set), 5);
        cmp("single_ready", int'(req_ready), 4);
        tick();
        req_valid = '0;
        #1;
        cmp("single_resp_valid", int'(resp_valid), 1);
        cmp("single_resp_id", int'(resp_id), 2);
        cmp("single_resp_set", int'(resp_set), 5);
        cmp("single_resp_way", int'(resp_way), 3);
        acc_en = 1'b1; acc_set = 6'd9;
        #1;
        cmp("acc_access_en", int'(lru_access_en), 1);
        cmp("acc_access_set", int'(lru_access_set), 9);
        tick();
        acc_en = 1'b0; acc_hit = 1'b1; acc_hit_way = 2'd2;
        #1;
        cmp("acc_update_en", int'(lru_update_en), 1);
        cmp("acc_update_way", int'(lru_update_way), 2);
        cmp("acc_not_dropped", int'(acc_dropped), 0);
        tick();
        acc_hit = 1'b0; acc_en = 1'b1; req_valid = 4'b0001;
        #1;
        cmp("drop_access_en", int'(lru_access_en), 0);
        tick();
        acc_en = 1'b0; req_valid = '0; acc_hit = 1'b1; acc_hit_way = 2'd1;
        #1;
        cmp("drop_flag", int'(acc_dropped), 1);
        cmp("drop_no_update", int'(lru_update_en), 0);
        tick();
        acc_hit = 1'b0; acc_en = 1'b1;
        tick();
        acc_en = 1'b0;
        tick();
        req_valid = 4'b1111; acc_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            cmp("starve_fill_en", int'(lru_fill_en), (k == 3) ? 0 : 1);
            cmp("starve_access_en", int'(lru_access_en), (k == 3) ? 1 : 0);
            tick();
        end
        acc_en = 1'b0;
        tick();
        #1;
        cmp("pend_resp_valid", int'(resp_valid), 1);
        rst_n = 1'b0; chk = 1'b0; mreset();
        #1;
        cmp("async_resp_valid", int'(resp_valid), 0);
        cmp("async_acc_dropped", int'(acc_dropped), 0);
        tick(); tick();
        rst_n = 1'b1; chk = 1'b1;
        #1;
        cmp("post_rst_ready", int'(req_ready), 1);
        for (int c = 0; c < 3000; c++) begin
            tick();
            req_valid    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            req_set      = (N*SIW)'({$urandom, $urandom});
            acc_en       = $urandom_range(0, 1) == 1;
            acc_set      = SIW'($urandom);
            acc_hit      = $urandom_range(0, 1) == 1;
            acc_hit_way  = WIW'($urandom);
            lru_fill_way = WIW'($urandom);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
